// File: rtl/wdt_rst_ctrl.sv
// Watchdog timeout counter with optional interrupt-first response and a
// system reset pulse of programmable length 2^(rpl+1) pclk cycles.
module wdt_rst_ctrl #(
  parameter int CNT_W    = 32,
  parameter int RPL_W    = 3,
  parameter int HC_RPL   = 0,
  parameter int DFLT_RPL = 0
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             wdt_en,
  input  logic             rsp_mode,
  input  logic [CNT_W-1:0] top,
  input  logic             restart,
  input  logic             intr_clr,
  input  logic             rpl_wr,
  input  logic [RPL_W-1:0] rpl_wdata,
  output logic [RPL_W-1:0] rpl,
  output logic [CNT_W-1:0] ccvr,
  output logic             wdt_intr,
  output logic             wdt_sys_rst,
  output logic             rst_busy
);

  // Longest pulse is 2^(2^RPL_W) cycles, so the pulse counter needs 2^RPL_W bits.
  localparam int PW = 2 ** RPL_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    INTR  = 2'd2,
    RST   = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] ccvr_reg, ccvr_next;
  logic             intr_reg, intr_next;
  logic             pulse_reg, pulse_next;
  logic [PW-1:0]    pcnt_reg, pcnt_next;
  logic [RPL_W-1:0] rpl_reg;

  logic             cnt_zero;
  logic [CNT_W-1:0] ccvr_dec;
  logic [RPL_W:0]   rpl_exp;
  logic [PW:0]      pulse_len;
  logic [PW-1:0]    pulse_load;
  logic             enter_rst;

  assign cnt_zero   = (ccvr_reg == '0);
  assign ccvr_dec   = ccvr_reg - CNT_W'(1);
  assign rpl_exp    = {1'b0, rpl_reg} + (RPL_W + 1)'(1);
  assign pulse_len  = (PW + 1)'(1) << rpl_exp;
  assign pulse_load = PW'(pulse_len - (PW + 1)'(1));

  generate
    if (HC_RPL != 0) begin : g_hc_rpl
      logic rpl_wr_unused;
      assign rpl_wr_unused = ^{rpl_wr, rpl_wdata};
      assign rpl_reg       = RPL_W'(DFLT_RPL);
    end else begin : g_rw_rpl
      // The field may change mid-pulse; the pulse counter already holds its length.
      always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
          rpl_reg <= RPL_W'(DFLT_RPL);
        end else if (rpl_wr) begin
          rpl_reg <= rpl_wdata;
        end
      end
    end
  endgenerate

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_reg <= IDLE;
      ccvr_reg  <= '0;
      intr_reg  <= 1'b0;
      pulse_reg <= 1'b0;
      pcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ccvr_reg  <= ccvr_next;
      intr_reg  <= intr_next;
      pulse_reg <= pulse_next;
      pcnt_reg  <= pcnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ccvr_next  = ccvr_reg;
    intr_next  = intr_reg;
    pulse_next = pulse_reg;
    pcnt_next  = pcnt_reg;
    enter_rst  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (wdt_en) begin
          ccvr_next  = top;
          state_next = COUNT;
        end
      end

      COUNT: begin
        if (!wdt_en) begin
          state_next = IDLE;
        end else if (restart) begin
          ccvr_next = top;
        end else if (cnt_zero) begin
          if (rsp_mode) begin
            intr_next  = 1'b1;
            ccvr_next  = top;
            state_next = INTR;
          end else begin
            enter_rst = 1'b1;
          end
        end else begin
          ccvr_next = ccvr_dec;
        end
      end

      INTR: begin
        if (!wdt_en) begin
          intr_next  = 1'b0;
          state_next = IDLE;
        end else if (intr_clr) begin
          // Clearing beats a coincident expiry; the count then restarts from top.
          intr_next  = 1'b0;
          state_next = COUNT;
          ccvr_next  = (restart || cnt_zero) ? top : ccvr_dec;
        end else if (restart) begin
          ccvr_next = top;
        end else if (cnt_zero) begin
          enter_rst = 1'b1;
        end else begin
          ccvr_next = ccvr_dec;
        end
      end

      RST: begin
        if (pcnt_reg == '0) begin
          pulse_next = 1'b0;
          intr_next  = 1'b0;
          ccvr_next  = top;
          state_next = wdt_en ? COUNT : IDLE;
        end else begin
          pcnt_next = pcnt_reg - PW'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (enter_rst) begin
      state_next = RST;
      pulse_next = 1'b1;
      pcnt_next  = pulse_load;
    end
  end

  assign rpl         = rpl_reg;
  assign ccvr        = ccvr_reg;
  assign wdt_intr    = intr_reg;
  assign wdt_sys_rst = pulse_reg;
  assign rst_busy    = pulse_reg;

endmodule

// File: tb/tb_wdt_rst_ctrl.sv
// Bench for wdt_rst_ctrl: a writable-RPL and a hard-coded-RPL instance share
// stimulus and are compared every cycle against a behavioural model.
module tb_wdt_rst_ctrl;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic        presetn, wdt_en, rsp_mode, restart, intr_clr, rpl_wr;
  logic [31:0] top;
  logic [2:0]  rpl_wdata;

  logic [2:0]  rpl_a, rpl_b;
  logic [31:0] ccvr_a, ccvr_b;
  logic        intr_a, intr_b, sys_a, sys_b, busy_a, busy_b;

  int n_tests = 0;
  int n_fail  = 0;

  wdt_rst_ctrl #(.CNT_W(32), .RPL_W(3), .HC_RPL(0), .DFLT_RPL(0)) dut_a (
    .pclk(pclk), .presetn(presetn), .wdt_en(wdt_en), .rsp_mode(rsp_mode), .top(top),
    .restart(restart), .intr_clr(intr_clr), .rpl_wr(rpl_wr), .rpl_wdata(rpl_wdata),
    .rpl(rpl_a), .ccvr(ccvr_a), .wdt_intr(intr_a), .wdt_sys_rst(sys_a), .rst_busy(busy_a)
  );

  wdt_rst_ctrl #(.CNT_W(32), .RPL_W(3), .HC_RPL(1), .DFLT_RPL(2)) dut_b (
    .pclk(pclk), .presetn(presetn), .wdt_en(wdt_en), .rsp_mode(rsp_mode), .top(top),
    .restart(restart), .intr_clr(intr_clr), .rpl_wr(rpl_wr), .rpl_wdata(rpl_wdata),
    .rpl(rpl_b), .ccvr(ccvr_b), .wdt_intr(intr_b), .wdt_sys_rst(sys_b), .rst_busy(busy_b)
  );

  // Model: "running" = watchdog enabled, "pulse_left" = remaining reset cycles.
  typedef struct {
    bit     running;
    bit     intr;
    int     pulse_left;
    longint cnt;
    int     rpl;
  } mdl_t;

  mdl_t ma, mb;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_reset(input int dflt);
    mdl_t m;
    m.running    = 1'b0;
    m.intr       = 1'b0;
    m.pulse_left = 0;
    m.cnt        = 0;
    m.rpl        = dflt;
    return m;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input bit hc);
    mdl_t   n  = m;
    longint tv = longint'(top);
    if (m.pulse_left > 0) begin
      n.pulse_left = m.pulse_left - 1;
      if (n.pulse_left == 0) begin
        n.intr    = 1'b0;
        n.cnt     = tv;
        n.running = wdt_en;
      end
    end else if (!m.running) begin
      if (wdt_en) begin
        n.running = 1'b1;
        n.cnt     = tv;
      end
    end else if (!wdt_en) begin
      n.running = 1'b0;
      n.intr    = 1'b0;
    end else if (m.intr && intr_clr) begin
      n.intr = 1'b0;
      n.cnt  = (restart || m.cnt == 0) ? tv : m.cnt - 1;
    end else if (restart) begin
      n.cnt = tv;
    end else if (m.cnt != 0) begin
      n.cnt = m.cnt - 1;
    end else if (rsp_mode && !m.intr) begin
      n.intr = 1'b1;
      n.cnt  = tv;
    end else begin
      n.pulse_left = 1 << (m.rpl + 1);
    end
    if (rpl_wr && !hc) n.rpl = int'(rpl_wdata);
    return n;
  endfunction

  task automatic compare_all();
    check("a_ccvr", ccvr_a, ma.cnt);
    check("a_intr", intr_a, ma.intr);
    check("a_sys_rst", sys_a, ma.pulse_left > 0);
    check("a_busy", busy_a, ma.pulse_left > 0);
    check("a_rpl", rpl_a, ma.rpl);
    check("b_ccvr", ccvr_b, mb.cnt);
    check("b_intr", intr_b, mb.intr);
    check("b_sys_rst", sys_b, mb.pulse_left > 0);
    check("b_busy", busy_b, mb.pulse_left > 0);
    check("b_rpl", rpl_b, mb.rpl);
  endtask

  task automatic tick();
    @(posedge pclk);
    if (!presetn) begin
      ma = mdl_reset(0);
      mb = mdl_reset(2);
    end else begin
      ma = mdl_step(ma, 1'b0);
      mb = mdl_step(mb, 1'b1);
    end
    #1;
    compare_all();
  endtask

  task automatic wait_idle();
    int g = 0;
    wdt_en = 0; restart = 0; intr_clr = 0; rpl_wr = 0;
    while ((ma.running || ma.pulse_left > 0 || mb.running || mb.pulse_left > 0) && g < 600) begin
      tick();
      g++;
    end
    check("idle_timeout", g < 600, 1);
  endtask

  task automatic write_rpl(input logic [2:0] v);
    rpl_wdata = v; rpl_wr = 1;
    tick();
    rpl_wr = 0;
    check("rpl_write", rpl_a, v);
    check("rpl_hardcoded", rpl_b, 2);
  endtask

  int n, wa, wb, g;
  bit seen_rst, seen_intr;

  initial begin
    presetn = 0; wdt_en = 0; rsp_mode = 0; top = 0;
    restart = 0; intr_clr = 0; rpl_wr = 0; rpl_wdata = 0;
    ma = mdl_reset(0);
    mb = mdl_reset(2);
    tick(); tick();
    check("reset_ccvr", ccvr_a, 0);
    check("reset_sys_rst", sys_a, 0);
    check("reset_rpl_b", rpl_b, 2);
    presetn = 1;
    tick();

    // mode0, top=9, rpl=3: rise 11 edges after enable, 16 cycles high (hard-coded copy: 8)
    write_rpl(3);
    rsp_mode = 0; top = 9; wdt_en = 1;
    n = 0;
    while (!sys_a && n < 100) begin tick(); n++; end
    check("rise_latency", n, 11);
    wa = 0; wb = 0; g = 0;
    while ((sys_a || sys_b) && g < 600) begin
      if (sys_a) wa++;
      if (sys_b) wb++;
      tick(); g++;
    end
    check("pulse_width", wa, 16);
    check("hc_pulse_width", wb, 8);
    wait_idle();

    // RPL sweep with top=0: width 2^(r+1), then one low cycle, then the next pulse
    for (int r = 0; r < 8; r++) begin
      write_rpl(3'(r));
      top = 0; rsp_mode = 0; wdt_en = 1;
      n = 0;
      while (!sys_a && n < 20) begin tick(); n++; end
      check("sweep_rise", n, 2);
      wa = 0;
      while (sys_a && wa < 600) begin wa++; tick(); end
      check("sweep_width", wa, 1 << (r + 1));
      tick();
      check("sweep_gap_then_high", sys_a, 1);
      wait_idle();
    end

    // mode1, intr_clr two cycles after the interrupt: no reset, interrupt again
    write_rpl(1);
    rsp_mode = 1; top = 4; wdt_en = 1;
    n = 0;
    while (!intr_a && n < 50) begin tick(); n++; end
    check("m1_intr_seen", intr_a, 1);
    tick();
    intr_clr = 1; tick(); intr_clr = 0;
    seen_rst = 0; seen_intr = 0;
    repeat (7) begin
      tick();
      if (sys_a) seen_rst = 1;
      if (intr_a) seen_intr = 1;
    end
    check("clr_no_reset", seen_rst, 0);
    check("intr_again", seen_intr, 1);
    wait_idle();

    // mode1, no clear: reset 5 cycles after the interrupt, interrupt gone afterwards
    rsp_mode = 1; top = 4; wdt_en = 1;
    n = 0;
    while (!intr_a && n < 50) begin tick(); n++; end
    n = 0;
    while (!sys_a && n < 50) begin tick(); n++; end
    check("intr_to_reset", n, 5);
    wait_idle();
    check("intr_after_pulse", intr_a, 0);

    // periodic restart keeps the watchdog quiet, including a kick on the ccvr==0 cycle
    for (int k = 0; k < 2; k++) begin
      top = (k == 0) ? 32'd5 : 32'd2;
      rsp_mode = k[0];
      wdt_en = 1;
      seen_rst = 0; seen_intr = 0;
      for (int i = 0; i < 60; i++) begin
        restart = (i % 3 == 0);
        tick();
        if (sys_a || sys_b) seen_rst = 1;
        if (intr_a || intr_b) seen_intr = 1;
      end
      restart = 0;
      check("restart_no_reset", seen_rst, 0);
      check("restart_no_intr", seen_intr, 0);
      wait_idle();
    end

    // wide load value
    top = 32'hFFFF_FFFF; rsp_mode = 0; wdt_en = 1;
    repeat (20) tick();
    wait_idle();

    // randomized traffic
    for (int seg = 0; seg < 30; seg++) begin
      top = $urandom_range(0, 15);
      rsp_mode = 1'($urandom_range(0, 1));
      wdt_en = 1;
      for (int i = 0; i < 100; i++) begin
        restart  = ($urandom_range(0, 9) == 0);
        intr_clr = ($urandom_range(0, 5) == 0);
        rpl_wr   = 0;
        if (ma.pulse_left == 0 && mb.pulse_left == 0 && $urandom_range(0, 19) == 0) begin
          rpl_wr    = 1;
          rpl_wdata = 3'($urandom_range(0, 3));
        end
        if ($urandom_range(0, 39) == 0) wdt_en = !wdt_en;
        if ($urandom_range(0, 29) == 0) top = $urandom_range(0, 15);
        tick();
      end
      restart = 0; intr_clr = 0; rpl_wr = 0;
    end
    wait_idle();

    // asynchronous reset in the middle of a long pulse
    write_rpl(7);
    top = 0; rsp_mode = 0; wdt_en = 1;
    repeat (10) tick();
    check("pre_reset_pulse_on", sys_a, 1);
    #3 presetn = 0;
    #1;
    ma = mdl_reset(0);
    mb = mdl_reset(2);
    check("async_sys_rst_a", sys_a, 0);
    check("async_busy_a", busy_a, 0);
    check("async_ccvr_a", ccvr_a, 0);
    check("async_sys_rst_b", sys_b, 0);
    repeat (3) tick();
    check("reset_rpl_a", rpl_a, 0);
    check("reset_rpl_b2", rpl_b, 2);
    #3 presetn = 1;
    wdt_en = 0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
